// File: rtl/vga_pixel_probe_if.sv
// Pixel-stream probe bundle: VGA stream in, probe request in, probe response out.
// master = stream/request source (game top or bench), slave = the probe itself.
interface vga_pixel_probe_if;
  logic       pix_ce;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       req_valid;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_r;
  logic [7:0] rsp_g;
  logic [7:0] rsp_b;
  logic       rsp_miss;
  logic       locked;

  modport master (
    output pix_ce, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_r, rsp_g, rsp_b, rsp_miss, locked
  );

  modport slave (
    input  pix_ce, vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b,
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_r, rsp_g, rsp_b, rsp_miss, locked
  );
endinterface

// File: rtl/vga_pixel_probe.sv
// VGA pixel probe: recovers visible x/y from sync/blank, checks frame geometry
// and captures the colour of one requested pixel from the next full frame.
//
// state | meaning
// IDLE  | ready for a request
// ARMED | request latched, waiting for the start of a full frame (vs fall)
// SEEK  | scanning the frame for the requested coordinate
// RESP  | result presented, held until the consumer accepts it
module vga_pixel_probe #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  vga_pixel_probe_if.slave io_probe
);
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_ARMED = 2'd1;
  localparam logic [1:0]  ST_SEEK  = 2'd2;
  localparam logic [1:0]  ST_RESP  = 2'd3;
  localparam logic [9:0]  CNT_MAX  = 10'd1023;
  localparam logic [9:0]  LP_H     = 10'(H_ACTIVE);
  localparam logic [10:0] LP_V     = 11'(V_ACTIVE);

  logic       r_prev_hs, r_prev_vs, r_line_act;
  logic [9:0] r_x_cnt, r_y_cnt, r_last_w;
  logic       r_prev_good, r_locked;
  logic [1:0] r_state;
  logic [9:0] r_req_x, r_req_y;
  logic [7:0] r_rsp_r, r_rsp_g, r_rsp_b;
  logic       r_rsp_miss;

  logic        w_vs_fall, w_hs_fall, w_pix_vis, w_hit, w_good;
  logic [10:0] w_height;

  // vs edge outranks hs edge; a pixel only counts when neither edge is present
  assign w_vs_fall = io_probe.pix_ce & r_prev_vs & ~io_probe.vga_vs;
  assign w_hs_fall = io_probe.pix_ce & r_prev_hs & ~io_probe.vga_hs & ~w_vs_fall;
  assign w_pix_vis = io_probe.pix_ce & io_probe.vga_blank_n & ~w_vs_fall & ~w_hs_fall;
  assign w_hit     = w_pix_vis && (r_x_cnt == r_req_x) && (r_y_cnt == r_req_y);
  // a line still open at the vs edge counts towards the frame height
  assign w_height  = {1'b0, r_y_cnt} + {10'd0, r_line_act};
  assign w_good    = (r_last_w == LP_H) && (w_height == LP_V);

  // stream position tracking from sync edges and blank
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_hs  <= 1'b1;
      r_prev_vs  <= 1'b1;
      r_line_act <= 1'b0;
      r_x_cnt    <= '0;
      r_y_cnt    <= '0;
      r_last_w   <= '0;
    end else if (io_probe.pix_ce) begin
      r_prev_hs <= io_probe.vga_hs;
      r_prev_vs <= io_probe.vga_vs;
      if (w_vs_fall) begin
        r_x_cnt    <= '0;
        r_y_cnt    <= '0;
        r_line_act <= 1'b0;
      end else if (w_hs_fall) begin
        r_x_cnt    <= '0;
        r_line_act <= 1'b0;
        if (r_line_act) begin
          r_last_w <= r_x_cnt;
          if (r_y_cnt != CNT_MAX) r_y_cnt <= r_y_cnt + 10'd1;
        end
      end else if (io_probe.vga_blank_n) begin
        r_line_act <= 1'b1;
        if (r_x_cnt != CNT_MAX) r_x_cnt <= r_x_cnt + 10'd1;
      end
    end
  end

  // geometry lock: two consecutive good frames set it, one bad frame clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_good <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_vs_fall) begin
      r_prev_good <= w_good;
      r_locked    <= w_good & r_prev_good;
    end
  end

  // probe request/response sequencing
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_req_x    <= '0;
      r_req_y    <= '0;
      r_rsp_r    <= '0;
      r_rsp_g    <= '0;
      r_rsp_b    <= '0;
      r_rsp_miss <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io_probe.req_valid) begin
            r_req_x <= io_probe.req_x;
            r_req_y <= io_probe.req_y;
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_vs_fall) r_state <= ST_SEEK;
        end
        ST_SEEK: begin
          if (w_vs_fall) begin
            r_rsp_r    <= '0;
            r_rsp_g    <= '0;
            r_rsp_b    <= '0;
            r_rsp_miss <= 1'b1;
            r_state    <= ST_RESP;
          end else if (w_hit) begin
            r_rsp_r    <= io_probe.vga_r;
            r_rsp_g    <= io_probe.vga_g;
            r_rsp_b    <= io_probe.vga_b;
            r_rsp_miss <= 1'b0;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (io_probe.rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_probe.req_ready = (r_state == ST_IDLE);
  assign io_probe.rsp_valid = (r_state == ST_RESP);
  assign io_probe.rsp_r     = r_rsp_r;
  assign io_probe.rsp_g     = r_rsp_g;
  assign io_probe.rsp_b     = r_rsp_b;
  assign io_probe.rsp_miss  = r_rsp_miss;
  assign io_probe.locked    = r_locked;
endmodule

// File: tb/tb_vga_pixel_probe.sv
// Directed bench for vga_pixel_probe using a reduced 32x24 geometry so whole
// frames stay short. Pixel strobes arrive every other clock; the idle clocks
// carry deliberately junk stream values that the probe must ignore.
module tb_vga_pixel_probe;
  localparam int H = 32;
  localparam int V = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  vga_pixel_probe_if bus();

  vga_pixel_probe #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .io_probe (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sp_x = -1, sp_y = -1;
  logic [23:0] sp_rgb = 24'h0;
  int tgt_x = -1, tgt_y = -1;
  logic v_before, v_after, v_last;
  logic [23:0] rsp_rgb;
  assign rsp_rgb = {bus.rsp_r, bus.rsp_g, bus.rsp_b};

  function automatic logic [23:0] pix_rgb(input int x, input int y);
    if (x == sp_x && y == sp_y) return sp_rgb;
    return {8'(x + 1), 8'(y), 8'hA5};
  endfunction

  task automatic strobe(input logic bn, input logic hs, input logic vs, input logic [23:0] rgb);
    bus.pix_ce = 1'b1; bus.vga_blank_n = bn; bus.vga_hs = hs; bus.vga_vs = vs;
    {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
    @(posedge clk); #1;
    v_last = bus.rsp_valid;
    bus.pix_ce = 1'b0; bus.vga_blank_n = 1'b1; bus.vga_hs = 1'b0; bus.vga_vs = 1'b0;
    {bus.vga_r, bus.vga_g, bus.vga_b} = 24'h777777;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int w, input int lines);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x == tgt_x && y == tgt_y) begin
          v_before = bus.rsp_valid;
          strobe(1'b1, 1'b1, 1'b1, pix_rgb(x, y));
          v_after = v_last;
        end else begin
          strobe(1'b1, 1'b1, 1'b1, pix_rgb(x, y));
        end
      end
      strobe(1'b0, 1'b1, 1'b1, 24'h0);
      strobe(1'b0, 1'b1, 1'b1, 24'h0);
      strobe(1'b0, 1'b0, 1'b1, 24'h0);
      strobe(1'b0, 1'b0, 1'b1, 24'h0);
      strobe(1'b0, 1'b1, 1'b1, 24'h0);
    end
    repeat (3) strobe(1'b0, 1'b1, 1'b1, 24'h0);
    repeat (2) strobe(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (3) strobe(1'b0, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic do_req(input int x, input int y);
    bus.req_valid = 1'b1; bus.req_x = 10'(x); bus.req_y = 10'(y);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 1", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (rsp_rgb !== 24'h0) begin n_fail++; $display("FAIL rst_rsp_rgb: got %h expected 000000", rsp_rgb); end
    n_tests++; if (bus.rsp_miss !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_miss: got %b expected 0", bus.rsp_miss); end
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", bus.locked); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL lock_frame1: got %b expected 0", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_frame2: got %b expected 1", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL lock_frame3: got %b expected 1", bus.locked); end
  endtask

  task automatic test_capture_origin();
    sp_x = 0; sp_y = 0; sp_rgb = 24'h123456;
    do_req(0, 0);
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL org_req_ready_busy: got %b expected 0", bus.req_ready); end
    send_frame(H, V);
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL org_armed_no_rsp: got %b expected 0", bus.rsp_valid); end
    tgt_x = 0; tgt_y = 0;
    send_frame(H, V);
    tgt_x = -1; tgt_y = -1;
    n_tests++; if (v_before !== 1'b0) begin n_fail++; $display("FAIL org_valid_before: got %b expected 0", v_before); end
    n_tests++; if (v_after !== 1'b1) begin n_fail++; $display("FAIL org_latency: got %b expected 1", v_after); end
    n_tests++; if (rsp_rgb !== 24'h123456) begin n_fail++; $display("FAIL org_rgb: got %h expected 123456", rsp_rgb); end
    n_tests++; if (bus.rsp_miss !== 1'b0) begin n_fail++; $display("FAIL org_miss: got %b expected 0", bus.rsp_miss); end
    ack();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL org_ack_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL org_ack_idle: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_hold();
    sp_x = H - 1; sp_y = V - 1; sp_rgb = 24'hFF0080;
    do_req(H - 1, V - 1);
    send_frame(H, V);
    tgt_x = H - 1; tgt_y = V - 1;
    send_frame(H, V);
    tgt_x = -1; tgt_y = -1;
    n_tests++; if (v_before !== 1'b0) begin n_fail++; $display("FAIL hold_valid_before: got %b expected 0", v_before); end
    n_tests++; if (v_after !== 1'b1) begin n_fail++; $display("FAIL hold_latency: got %b expected 1", v_after); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin bus.req_valid = 1'b1; bus.req_x = 10'd1; bus.req_y = 10'd1; end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n_tests++;
      if (bus.rsp_valid !== 1'b1 || rsp_rgb !== 24'hFF0080 || bus.rsp_miss !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b rgb=%h miss=%b expected 1/ff0080/0", i, bus.rsp_valid, rsp_rgb, bus.rsp_miss);
      end
    end
    ack();
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_ack_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_ack_idle: got %b expected 1", bus.req_ready); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_no_queue: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_miss();
    sp_x = -1; sp_y = -1;
    do_req(H + 8, 10);
    send_frame(H, V);
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_armed_no_rsp: got %b expected 0", bus.rsp_valid); end
    send_frame(H, V);
    n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL miss_valid: got %b expected 1", bus.rsp_valid); end
    n_tests++; if (bus.rsp_miss !== 1'b1) begin n_fail++; $display("FAIL miss_flag: got %b expected 1", bus.rsp_miss); end
    n_tests++; if (rsp_rgb !== 24'h0) begin n_fail++; $display("FAIL miss_rgb: got %h expected 000000", rsp_rgb); end
    ack();
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL miss_ack_idle: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_mid_pixel();
    sp_x = -1; sp_y = -1;
    do_req(7, 3);
    send_frame(H, V);
    tgt_x = 7; tgt_y = 3;
    send_frame(H, V);
    tgt_x = -1; tgt_y = -1;
    n_tests++; if (v_after !== 1'b1) begin n_fail++; $display("FAIL mid_latency: got %b expected 1", v_after); end
    n_tests++; if (rsp_rgb !== 24'h0803A5) begin n_fail++; $display("FAIL mid_rgb: got %h expected 0803a5", rsp_rgb); end
    n_tests++; if (bus.rsp_miss !== 1'b0) begin n_fail++; $display("FAIL mid_miss: got %b expected 0", bus.rsp_miss); end
    ack();
  endtask

  task automatic test_relock();
    n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL relock_pre: got %b expected 1", bus.locked); end
    send_frame(H - 1, V);
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL relock_bad_width: got %b expected 0", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL relock_good1: got %b expected 0", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL relock_good2: got %b expected 1", bus.locked); end
    send_frame(H, V - 1);
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL relock_bad_height: got %b expected 0", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL relock_h_good1: got %b expected 0", bus.locked); end
    send_frame(H, V);
    n_tests++; if (bus.locked !== 1'b1) begin n_fail++; $display("FAIL relock_h_good2: got %b expected 1", bus.locked); end
  endtask

  task automatic test_reset_mid();
    do_req(5, 5);
    n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", bus.req_ready); end
    for (int x = 0; x < H; x++) strobe(1'b1, 1'b1, 1'b1, pix_rgb(x, 0));
    rst_n = 1'b0;
    #5;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_req_ready: got %b expected 1", bus.req_ready); end
    n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_tests++; if (bus.locked !== 1'b0) begin n_fail++; $display("FAIL rmid_locked: got %b expected 0", bus.locked); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_post_idle: got %b expected 1", bus.req_ready); end
  endtask

  initial begin
    bus.pix_ce = 1'b0; bus.vga_hs = 1'b1; bus.vga_vs = 1'b1; bus.vga_blank_n = 1'b0;
    bus.vga_r = 8'h0; bus.vga_g = 8'h0; bus.vga_b = 8'h0;
    bus.req_valid = 1'b0; bus.req_x = 10'd0; bus.req_y = 10'd0; bus.rsp_ready = 1'b0;
    test_reset();
    test_lock();
    test_capture_origin();
    test_hold();
    test_miss();
    test_mid_pixel();
    test_relock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
